conv_instgen_tiled: RTL and testbench

- Next-generation CONV stride instruction generator. Sits between the CSR block and the decoder.
- Walks output coordinates directly (ox, oy), with separate horizontal/vertical strides.
- Tiles output channels into groups of OCH_TILE. Each tile gets a full spatial sweep with its own kernel base address.
- Feature, kernel and writeback addresses are formed with incremental adders only; no multiplier sits in the per-instruction path.

---
 rtl/conv_instgen_tiled_if.sv | 54 +++++
 rtl/conv_instgen_tiled.sv | 166 ++++++++++++++++
 tb/tb_conv_instgen_tiled.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_instgen_tiled_if.sv
// Bus bundle for conv_instgen_tiled: CSR command fields in, stride instructions out.
// The master modport is the generator side; slave is the CSR/decoder side.
interface conv_instgen_tiled_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int FRAM_AW = 14,
    parameter int KRAM_AW = 12
);
    logic [ADDR_W-1:0]  feature_baseaddr, kernel_baseaddr, output_baseaddr;
    logic [DATA_W-1:0]  feature_width, feature_height, feature_chin, feature_chout;
    logic [DATA_W-1:0]  kernel_sizeh, kernel_sizew, stride_h, stride_w;
    logic [DATA_W-1:0]  output_width, output_height;
    logic               has_bias, has_relu;
    logic               csrcmd_valid, instgen_ready;
    logic               inst_valid, decoder_ready;
    logic [FRAM_AW-1:0] stride_feature_baseaddr, stride_wb_baseaddr;
    logic [KRAM_AW-1:0] stride_kernel_baseaddr;
    logic [DATA_W-1:0]  stride_wb_ch_offset, stride_tile_chout;
    logic [DATA_W-1:0]  stride_feature_chin, stride_feature_width, stride_feature_height;
    logic [DATA_W-1:0]  stride_kernel_sizeh, stride_kernel_sizew;
    logic               stride_has_bias, stride_has_relu;
    logic               conv_complete, cfg_error;
    logic [31:0]        stall_cnt;

    modport master (
        input  feature_baseaddr, kernel_baseaddr, output_baseaddr,
        input  feature_width, feature_height, feature_chin, feature_chout,
        input  kernel_sizeh, kernel_sizew, stride_h, stride_w,
        input  output_width, output_height, has_bias, has_relu,
        input  csrcmd_valid, decoder_ready,
        output instgen_ready, inst_valid,
        output stride_feature_baseaddr, stride_wb_baseaddr, stride_kernel_baseaddr,
        output stride_wb_ch_offset, stride_tile_chout,
        output stride_feature_chin, stride_feature_width, stride_feature_height,
        output stride_kernel_sizeh, stride_kernel_sizew,
        output stride_has_bias, stride_has_relu,
        output conv_complete, cfg_error, stall_cnt
    );

    modport slave (
        output feature_baseaddr, kernel_baseaddr, output_baseaddr,
        output feature_width, feature_height, feature_chin, feature_chout,
        output kernel_sizeh, kernel_sizew, stride_h, stride_w,
        output output_width, output_height, has_bias, has_relu,
        output csrcmd_valid, decoder_ready,
        input  instgen_ready, inst_valid,
        input  stride_feature_baseaddr, stride_wb_baseaddr, stride_kernel_baseaddr,
        input  stride_wb_ch_offset, stride_tile_chout,
        input  stride_feature_chin, stride_feature_width, stride_feature_height,
        input  stride_kernel_sizeh, stride_kernel_sizew,
        input  stride_has_bias, stride_has_relu,
        input  conv_complete, cfg_error, stall_cnt
    );
endinterface

// File: rtl/conv_instgen_tiled.sv
// Tiled CONV stride instruction generator: walks (tile, oy, ox) with adder-only address updates.
// Optional backpressure counter enabled by defining INSTGEN_STALL_CNT_EN.
module conv_instgen_tiled #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int FRAM_AW  = 14,
    parameter int KRAM_AW  = 12,
    parameter int OCH_TILE = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    conv_instgen_tiled_if.master bus
);
    typedef enum logic [1:0] {IDLE, INIT, EXEC, DONE} state_e;

    localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);
    localparam logic [DATA_W-1:0] TILE_W = DATA_W'(OCH_TILE);

    state_e state_q, state_d;

    logic [FRAM_AW-1:0] fbase_q, obase_q, rowstep_q, tile_wb_step_q;
    logic [FRAM_AW-1:0] row_q, feat_q, wb_q, wb_tile_q;
    logic [KRAM_AW-1:0] kbase0_q, ktile_q, kbase_q;
    logic [DATA_W-1:0]  chin_q, fw_q, fh_q, kh_q, kw_q, sh_q, sw_q, ow_q, oh_q, chout_q;
    logic [DATA_W-1:0]  wbch_q, ntiles_q, last_chout_q, tile_chout_q;
    logic [DATA_W-1:0]  ox_q, oy_q, tile_q;
    logic               bias_q, relu_q, cfg_error_q;

    logic [DATA_W:0]    nt_full;
    logic [DATA_W-1:0]  ntiles_init, last_chout_init;
    logic               cfg_bad, ox_end, oy_end, tile_end;

    // Tile count rounds up in DATA_W+1 bits so a near-max chout cannot wrap.
    assign nt_full         = ({1'b0, chout_q} + (DATA_W+1)'(OCH_TILE - 1)) / (DATA_W+1)'(OCH_TILE);
    assign ntiles_init     = nt_full[DATA_W-1:0];
    assign last_chout_init = chout_q - (ntiles_init - ONE) * TILE_W;
    assign cfg_bad  = (sh_q == '0) || (sw_q == '0) || (ow_q == '0) || (oh_q == '0) || (chout_q == '0);
    assign ox_end   = (ox_q == ow_q - ONE);
    assign oy_end   = (oy_q == oh_q - ONE);
    assign tile_end = (tile_q == ntiles_q - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d takes its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.csrcmd_valid) state_d = INIT;
            INIT:    state_d = cfg_bad ? DONE : EXEC;
            EXEC:    if (bus.decoder_ready && ox_end && oy_end && tile_end) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbase_q <= '0; obase_q <= '0; rowstep_q <= '0; tile_wb_step_q <= '0;
            row_q <= '0; feat_q <= '0; wb_q <= '0; wb_tile_q <= '0;
            kbase0_q <= '0; ktile_q <= '0; kbase_q <= '0;
            chin_q <= '0; fw_q <= '0; fh_q <= '0; kh_q <= '0; kw_q <= '0;
            sh_q <= '0; sw_q <= '0; ow_q <= '0; oh_q <= '0; chout_q <= '0;
            wbch_q <= '0; ntiles_q <= '0; last_chout_q <= '0; tile_chout_q <= '0;
            ox_q <= '0; oy_q <= '0; tile_q <= '0;
            bias_q <= 1'b0; relu_q <= 1'b0; cfg_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.csrcmd_valid) begin
                    fbase_q     <= bus.feature_baseaddr[2 +: FRAM_AW];
                    obase_q     <= bus.output_baseaddr[2 +: FRAM_AW];
                    kbase0_q    <= bus.kernel_baseaddr[2 +: KRAM_AW];
                    chin_q      <= bus.feature_chin;
                    chout_q     <= bus.feature_chout;
                    fw_q        <= bus.feature_width;
                    fh_q        <= bus.feature_height;
                    kh_q        <= bus.kernel_sizeh;
                    kw_q        <= bus.kernel_sizew;
                    sh_q        <= bus.stride_h;
                    sw_q        <= bus.stride_w;
                    ow_q        <= bus.output_width;
                    oh_q        <= bus.output_height;
                    bias_q      <= bus.has_bias;
                    relu_q      <= bus.has_relu;
                    cfg_error_q <= 1'b0;
                end
                INIT: begin
                    ktile_q        <= KRAM_AW'(chin_q) * KRAM_AW'(kh_q) * KRAM_AW'(kw_q) * KRAM_AW'(OCH_TILE);
                    rowstep_q      <= FRAM_AW'(sh_q) * FRAM_AW'(fw_q);
                    wbch_q         <= ow_q * oh_q;
                    tile_wb_step_q <= FRAM_AW'(ow_q) * FRAM_AW'(oh_q) * FRAM_AW'(OCH_TILE);
                    ntiles_q       <= ntiles_init;
                    last_chout_q   <= last_chout_init;
                    tile_chout_q   <= (ntiles_init == ONE) ? last_chout_init : TILE_W;
                    ox_q <= '0; oy_q <= '0; tile_q <= '0;
                    row_q <= fbase_q; feat_q <= fbase_q;
                    wb_q <= obase_q; wb_tile_q <= obase_q;
                    kbase_q <= kbase0_q;
                    if (cfg_bad) cfg_error_q <= 1'b1;
                end
                EXEC: if (bus.decoder_ready) begin
                    if (!ox_end) begin
                        ox_q   <= ox_q + ONE;
                        feat_q <= feat_q + FRAM_AW'(sw_q);
                        wb_q   <= wb_q + FRAM_AW'(1);
                    end else if (!oy_end) begin
                        ox_q   <= '0;
                        oy_q   <= oy_q + ONE;
                        row_q  <= row_q + rowstep_q;
                        feat_q <= row_q + rowstep_q;
                        wb_q   <= wb_q + FRAM_AW'(1);
                    end else begin
                        // Tile wrap: spatial walk restarts, kernel and writeback move one tile on.
                        ox_q <= '0; oy_q <= '0;
                        row_q <= fbase_q; feat_q <= fbase_q;
                        tile_q       <= tile_q + ONE;
                        kbase_q      <= kbase_q + ktile_q;
                        wb_tile_q    <= wb_tile_q + tile_wb_step_q;
                        wb_q         <= wb_tile_q + tile_wb_step_q;
                        tile_chout_q <= (tile_q + ONE == ntiles_q - ONE) ? last_chout_q : TILE_W;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instgen_ready           = (state_q == IDLE);
    assign bus.inst_valid              = (state_q == EXEC);
    assign bus.conv_complete           = (state_q == DONE);
    assign bus.cfg_error               = cfg_error_q;
    assign bus.stride_feature_baseaddr = feat_q;
    assign bus.stride_kernel_baseaddr  = kbase_q;
    assign bus.stride_wb_baseaddr      = wb_q;
    assign bus.stride_wb_ch_offset     = wbch_q;
    assign bus.stride_tile_chout       = tile_chout_q;
    assign bus.stride_feature_chin     = chin_q;
    assign bus.stride_feature_width    = fw_q;
    assign bus.stride_feature_height   = fh_q;
    assign bus.stride_kernel_sizeh     = kh_q;
    assign bus.stride_kernel_sizew     = kw_q;
    assign bus.stride_has_bias         = bias_q;
    assign bus.stride_has_relu         = relu_q;

`ifdef INSTGEN_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   stall_q <= '0;
        else if (state_q == IDLE && bus.csrcmd_valid) stall_q <= '0;
        else if (state_q == EXEC && !bus.decoder_ready && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end
    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif

    // Byte-offset and high address bits are not part of the BRAM word address.
    logic unused_bits;
    assign unused_bits = ^{bus.feature_baseaddr[1:0], bus.feature_baseaddr[ADDR_W-1:FRAM_AW+2],
                           bus.output_baseaddr[1:0], bus.output_baseaddr[ADDR_W-1:FRAM_AW+2],
                           bus.kernel_baseaddr[1:0], bus.kernel_baseaddr[ADDR_W-1:KRAM_AW+2],
                           nt_full[DATA_W]};
endmodule

// File: tb/tb_conv_instgen_tiled.sv
// Self-checking bench for conv_instgen_tiled: loop-nest reference model, random backpressure.
// Stall-count expectations follow INSTGEN_STALL_CNT_EN.
module tb_conv_instgen_tiled;
    localparam int FRAM_AW = 14;
    localparam int KRAM_AW = 12;
    localparam int OCH     = 8;
    localparam int BUDGET  = 4000;
    localparam int SNAP_W  = 267;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_instgen_tiled_if bus();
    conv_instgen_tiled dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    typedef struct {
        longint unsigned fb, kb, ob, fw, fh, chin, chout, kh, kw, sh, sw, ow, oh;
        bit bias, relu;
    } cfg_t;
    typedef struct {
        logic [FRAM_AW-1:0] feat;
        logic [KRAM_AW-1:0] kb;
        logic [FRAM_AW-1:0] wb;
        logic [31:0]        tc;
    } inst_t;

    int checks = 0;
    int failures = 0;
    inst_t exp_q[$];
    logic [FRAM_AW-1:0] obs_feat[$];
    logic [FRAM_AW-1:0] obs_wb[$];
    logic [KRAM_AW-1:0] obs_kb[$];
    logic [31:0]        obs_tc[$];

    // Expected instruction stream straight from the coordinate formulas.
    function automatic void build_model(input cfg_t c);
        longint unsigned nt = (c.chout + OCH - 1) / OCH;
        exp_q.delete();
        for (longint unsigned t = 0; t < nt; t++)
            for (longint unsigned oy = 0; oy < c.oh; oy++)
                for (longint unsigned ox = 0; ox < c.ow; ox++) begin
                    inst_t e;
                    e.feat = FRAM_AW'((c.fb >> 2) + oy * c.sh * c.fw + ox * c.sw);
                    e.kb   = KRAM_AW'((c.kb >> 2) + t * OCH * c.chin * c.kh * c.kw);
                    e.wb   = FRAM_AW'((c.ob >> 2) + oy * c.ow + ox + t * c.ow * c.oh * OCH);
                    e.tc   = (t == nt - 1) ? 32'(c.chout - (nt - 1) * OCH) : 32'(OCH);
                    exp_q.push_back(e);
                end
    endfunction

    function automatic cfg_t base_cfg();
        cfg_t c;
        c.fb = 0; c.kb = 0; c.ob = 0; c.fw = 6; c.fh = 6; c.chin = 3; c.chout = 8;
        c.kh = 3; c.kw = 3; c.sh = 1; c.sw = 1; c.ow = 4; c.oh = 4; c.bias = 1; c.relu = 0;
        return c;
    endfunction

    task automatic drive_cfg(input cfg_t c);
        bus.feature_baseaddr = 32'(c.fb);    bus.kernel_baseaddr = 32'(c.kb);
        bus.output_baseaddr  = 32'(c.ob);    bus.feature_width   = 32'(c.fw);
        bus.feature_height   = 32'(c.fh);    bus.feature_chin    = 32'(c.chin);
        bus.feature_chout    = 32'(c.chout); bus.kernel_sizeh    = 32'(c.kh);
        bus.kernel_sizew     = 32'(c.kw);    bus.stride_h        = 32'(c.sh);
        bus.stride_w         = 32'(c.sw);    bus.output_width    = 32'(c.ow);
        bus.output_height    = 32'(c.oh);    bus.has_bias = c.bias; bus.has_relu = c.relu;
    endtask

    task automatic scramble();
        cfg_t c;
        c.fb = $urandom; c.kb = $urandom; c.ob = $urandom; c.fw = $urandom; c.fh = $urandom;
        c.chin = $urandom; c.chout = $urandom; c.kh = $urandom; c.kw = $urandom;
        c.sh = $urandom; c.sw = $urandom; c.ow = $urandom; c.oh = $urandom;
        c.bias = 1'($urandom); c.relu = 1'($urandom);
        drive_cfg(c);
    endtask

    function automatic logic [SNAP_W-1:0] snap();
        return {bus.stride_feature_baseaddr, bus.stride_kernel_baseaddr, bus.stride_wb_baseaddr,
                bus.stride_wb_ch_offset, bus.stride_tile_chout, bus.stride_feature_chin,
                bus.stride_feature_width, bus.stride_feature_height, bus.stride_kernel_sizeh,
                bus.stride_kernel_sizew, bus.stride_has_bias, bus.stride_has_relu, bus.inst_valid};
    endfunction

    // Issues one command and consumes its instructions; abort_after>0 asserts reset after that handshake.
    task automatic run_cmd(input cfg_t c, input int prob, input int abort_after);
        int got = 0, stalls = 0, last_hs = -10, n_exp;
        bit stalled_prev = 0, done = 0, injected = 0;
        logic [SNAP_W-1:0] held = '0;
        logic [31:0] exp_stall, stall_seen;
        inst_t e;
        build_model(c);
        n_exp = exp_q.size();
        obs_feat.delete(); obs_wb.delete(); obs_kb.delete(); obs_tc.delete();
        @(negedge clk);
        drive_cfg(c); bus.csrcmd_valid = 1'b1; bus.decoder_ready = 1'b0;
        checks++;
        if (bus.instgen_ready !== 1'b1) begin
            failures++; $display("FAIL accept_ready got=%b exp=1", bus.instgen_ready);
        end
        @(negedge clk);
        bus.csrcmd_valid = 1'b0; scramble();
        checks++;
        if ({bus.cfg_error, bus.instgen_ready, bus.inst_valid} !== 3'b000) begin
            failures++;
            $display("FAIL init_state err/ready/valid got=%b%b%b exp=000",
                     bus.cfg_error, bus.instgen_ready, bus.inst_valid);
        end
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            if (stalled_prev) begin
                checks++;
                if (snap() !== held) begin
                    failures++; $display("FAIL stall_hold got=%h exp=%h", snap(), held);
                end
            end
            if (bus.conv_complete === 1'b1) begin
                done = 1;
                checks++;
                if (got != n_exp || cyc != last_hs + 1 || bus.inst_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL complete_timing insts=%0d/%0d delay=%0d/1 valid=%b", got, n_exp,
                             cyc - last_hs, bus.inst_valid);
                end
            end else if (bus.inst_valid === 1'b1) begin
                bus.decoder_ready = (prob >= 100) ? 1'b1 : ($urandom_range(99) < prob);
                if (bus.decoder_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++; $display("FAIL extra_inst count=%0d exp=%0d", got + 1, n_exp);
                        done = 1;
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.stride_feature_baseaddr !== e.feat || bus.stride_kernel_baseaddr !== e.kb ||
                            bus.stride_wb_baseaddr !== e.wb || bus.stride_tile_chout !== e.tc) begin
                            failures++;
                            $display("FAIL inst[%0d] got/exp feat=%h/%h kb=%h/%h wb=%h/%h tc=%0d/%0d", got,
                                     bus.stride_feature_baseaddr, e.feat, bus.stride_kernel_baseaddr, e.kb,
                                     bus.stride_wb_baseaddr, e.wb, bus.stride_tile_chout, e.tc);
                        end
                    end
                    if (got == 0) begin
                        checks++;
                        if ({bus.stride_wb_ch_offset, bus.stride_feature_chin, bus.stride_feature_width,
                             bus.stride_feature_height, bus.stride_kernel_sizeh, bus.stride_kernel_sizew,
                             bus.stride_has_bias, bus.stride_has_relu} !==
                            {32'(c.ow * c.oh), 32'(c.chin), 32'(c.fw), 32'(c.fh), 32'(c.kh), 32'(c.kw),
                             c.bias, c.relu}) begin
                            failures++;
                            $display("FAIL passthrough woff=%0d/%0d chin=%0d/%0d fw=%0d/%0d kh=%0d/%0d",
                                     bus.stride_wb_ch_offset, c.ow * c.oh, bus.stride_feature_chin, c.chin,
                                     bus.stride_feature_width, c.fw, bus.stride_kernel_sizeh, c.kh);
                        end
                    end
                    obs_feat.push_back(bus.stride_feature_baseaddr); obs_wb.push_back(bus.stride_wb_baseaddr);
                    obs_kb.push_back(bus.stride_kernel_baseaddr);    obs_tc.push_back(bus.stride_tile_chout);
                    got++; last_hs = cyc;
                    if (got == abort_after) begin
                        @(posedge clk); #1;
                        rst_n = 1'b0; bus.decoder_ready = 1'b0;
                        return;
                    end
                end else begin
                    stalls++; held = snap();
                end
                stalled_prev = !bus.decoder_ready;
            end else begin
                stalled_prev = 0; bus.decoder_ready = 1'($urandom_range(1));
            end
            // A command offered mid-run must be ignored.
            bus.csrcmd_valid = (!injected && got == 2 && bus.inst_valid === 1'b1);
            if (bus.csrcmd_valid) injected = 1;
            if (!done) @(negedge clk);
        end
        bus.csrcmd_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL timeout insts=%0d exp=%0d", got, n_exp);
            return;
        end
`ifdef INSTGEN_STALL_CNT_EN
        exp_stall = 32'(stalls);
`else
        exp_stall = 32'd0;
`endif
        checks++;
        stall_seen = bus.stall_cnt;
        if (stall_seen !== exp_stall) begin
            failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_seen, exp_stall);
        end
        @(negedge clk);
        checks++;
        if ({bus.conv_complete, bus.instgen_ready, bus.inst_valid} !== 3'b010 || bus.stall_cnt !== exp_stall) begin
            failures++;
            $display("FAIL post_done cc/ready/valid=%b%b%b exp=010 stall=%0d exp=%0d", bus.conv_complete,
                     bus.instgen_ready, bus.inst_valid, bus.stall_cnt, exp_stall);
        end
    endtask

    task automatic test_reset();
        bus.csrcmd_valid = 1'b0; bus.decoder_ready = 1'b0; scramble();
        rst_n = 1'b0;
        #23;
        checks++;
        if ({snap(), bus.conv_complete, bus.cfg_error, bus.stall_cnt} !== '0 || bus.instgen_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs got=%h ready=%b exp=0 ready=1", snap(), bus.instgen_ready);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_cmd(base_cfg(), 100, 0);
        checks++;
        if (obs_feat.size() != 16) begin
            failures++; $display("FAIL basic_count got=%0d exp=16", obs_feat.size());
        end
        for (int i = 0; i < obs_feat.size() && i < 16; i++) begin
            checks++;
            if (obs_feat[i] !== FRAM_AW'((i / 4) * 6 + i % 4) || obs_wb[i] !== FRAM_AW'(i) || obs_tc[i] !== 32'd8) begin
                failures++;
                $display("FAIL basic[%0d] feat=%0d wb=%0d tc=%0d exp feat=%0d wb=%0d tc=8", i, obs_feat[i],
                         obs_wb[i], obs_tc[i], (i / 4) * 6 + i % 4, i);
            end
        end
    endtask

    task automatic test_stride2();
        cfg_t c = base_cfg();
        logic [FRAM_AW-1:0] want [9] = '{14'h40, 14'h42, 14'h44, 14'h4E, 14'h50, 14'h52, 14'h5C, 14'h5E, 14'h60};
        c.fw = 7; c.fh = 7; c.sh = 2; c.sw = 2; c.ow = 3; c.oh = 3; c.fb = 32'h100; c.chin = 1;
        run_cmd(c, 100, 0);
        checks++;
        if (obs_feat.size() != 9) begin
            failures++; $display("FAIL stride2_count got=%0d exp=9", obs_feat.size());
        end
        for (int i = 0; i < obs_feat.size() && i < 9; i++) begin
            checks++;
            if (obs_feat[i] !== want[i]) begin
                failures++; $display("FAIL stride2_feat[%0d] got=%h exp=%h", i, obs_feat[i], want[i]);
            end
        end
    endtask

    task automatic test_tiles();
        cfg_t c = base_cfg();
        c.fw = 4; c.fh = 4; c.chin = 2; c.chout = 20; c.ow = 2; c.oh = 2;
        run_cmd(c, 100, 0);
        checks++;
        if (obs_tc.size() != 12) begin
            failures++; $display("FAIL tiles_count got=%0d exp=12", obs_tc.size());
        end
        for (int i = 0; i < obs_tc.size() && i < 12; i++) begin
            checks++;
            if (obs_tc[i] !== ((i < 8) ? 32'd8 : 32'd4) || obs_kb[i] !== KRAM_AW'((i / 4) * 144) ||
                obs_wb[i] !== FRAM_AW'((i / 4) * 32 + i % 4)) begin
                failures++;
                $display("FAIL tiles[%0d] tc=%0d kb=%0d wb=%0d exp tc=%0d kb=%0d wb=%0d", i, obs_tc[i], obs_kb[i],
                         obs_wb[i], (i < 8) ? 8 : 4, (i / 4) * 144, (i / 4) * 32 + i % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        run_cmd(base_cfg(), 50, 0);
        run_cmd(base_cfg(), 25, 0);
    endtask

    task automatic test_cfg_error(input cfg_t c);
        bit saw_valid = 0;
        @(negedge clk);
        drive_cfg(c); bus.csrcmd_valid = 1'b1; bus.decoder_ready = 1'b1;
        @(negedge clk);
        bus.csrcmd_valid = 1'b0; saw_valid |= bus.inst_valid;
        checks++;
        if (bus.conv_complete !== 1'b0) begin
            failures++; $display("FAIL err_early_complete got=%b exp=0", bus.conv_complete);
        end
        @(negedge clk);
        saw_valid |= bus.inst_valid;
        checks++;
        if ({bus.conv_complete, bus.cfg_error} !== 2'b11) begin
            failures++; $display("FAIL err_done cc/err got=%b%b exp=11", bus.conv_complete, bus.cfg_error);
        end
        @(negedge clk);
        checks++;
        if ({bus.conv_complete, bus.cfg_error, bus.instgen_ready, saw_valid} !== 4'b0110) begin
            failures++;
            $display("FAIL err_idle cc/err/ready/sawvalid got=%b%b%b%b exp=0110", bus.conv_complete,
                     bus.cfg_error, bus.instgen_ready, saw_valid);
        end
    endtask

    task automatic test_errors();
        cfg_t c = base_cfg();
        c.sw = 0;
        test_cfg_error(c);
        run_cmd(base_cfg(), 100, 0);
        c = base_cfg(); c.oh = 0;
        test_cfg_error(c);
        c = base_cfg(); c.chout = 0;
        test_cfg_error(c);
        run_cmd(base_cfg(), 70, 0);
    endtask

    task automatic test_reset_mid();
        run_cmd(base_cfg(), 100, 5);
        #1;
        checks++;
        if ({snap(), bus.conv_complete, bus.cfg_error, bus.stall_cnt} !== '0 || bus.instgen_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got=%h cc=%b ready=%b exp=0 cc=0 ready=1", snap(), bus.conv_complete,
                     bus.instgen_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        run_cmd(base_cfg(), 100, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            cfg_t c;
            c.fb = $urandom; c.kb = $urandom; c.ob = $urandom;
            c.fw = $urandom_range(12, 1); c.fh = $urandom_range(12, 1);
            c.chin = $urandom_range(6, 1); c.chout = $urandom_range(30, 1);
            c.kh = $urandom_range(3, 1); c.kw = $urandom_range(3, 1);
            c.sh = $urandom_range(3, 1); c.sw = $urandom_range(3, 1);
            c.ow = $urandom_range(5, 1); c.oh = $urandom_range(5, 1);
            c.bias = 1'($urandom); c.relu = 1'($urandom);
            run_cmd(c, $urandom_range(100, 30), 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride2();
        test_tiles();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
